// File: rtl/phase_stall_ctrl.sv
// Stall controller: holds the phase counter while a slow access in ACCESS_PHASE is outstanding.
// Optional access timeout is enabled by defining PHASE_STALL_TIMEOUT_EN.
module phase_stall_ctrl #(
    parameter int ACCESS_PHASE   = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] phase,
    input  logic       needMem,
    input  logic       memAck,
    output logic       memReq,
    output logic       notUpdate,
    output logic       phaseError,
    output logic       timeoutError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] ACC_CODE = 5'(1 << ACCESS_PHASE);

    state_t state_q, state_d;
    logic   memReq_q;
    logic   phaseError_q;
    logic   acc;
    logic   phase_ok;
    logic   stall_d;

    assign acc      = (phase == ACC_CODE);
    assign phase_ok = !phase[4] && $onehot(phase[3:0]);

`ifdef PHASE_STALL_TIMEOUT_EN
    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tcnt_q, tcnt_d;
    logic       timeoutError_q;
    logic       expire;
    logic       timeout_hit;

    assign expire = (state_q == REQ) && (tcnt_q == TLAST);
`endif

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
`ifdef PHASE_STALL_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (acc && needMem) begin
                    state_d = REQ;
                    stall_d = 1'b1;
`ifdef PHASE_STALL_TIMEOUT_EN
                    tcnt_d = 8'd0;
`endif
                end
            end
            REQ: begin
                if (memAck) begin
                    state_d = DONE;
`ifdef PHASE_STALL_TIMEOUT_EN
                end else if (expire) begin
                    // Release the counter on expiry just as a real ack would.
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                    tcnt_d      = tcnt_q + 8'd1;
`endif
                end else begin
                    stall_d = 1'b1;
`ifdef PHASE_STALL_TIMEOUT_EN
                    tcnt_d = tcnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                // Wait for the phase to move on so a held counter cannot retrigger.
                if (!acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            memReq_q     <= 1'b0;
            phaseError_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            memReq_q <= (state_d == REQ);
            if (!phase_ok) begin
                phaseError_q <= 1'b1;
            end
        end
    end

`ifdef PHASE_STALL_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            tcnt_q         <= 8'd0;
            timeoutError_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            if (timeout_hit) begin
                timeoutError_q <= 1'b1;
            end
        end
    end

    assign timeoutError = timeoutError_q;
`else
    assign timeoutError = 1'b0;
`endif

    assign memReq     = memReq_q;
    assign phaseError = phaseError_q;
    assign notUpdate  = reset & stall_d;

endmodule

// File: tb/tb_phase_stall_ctrl.sv
// Scoreboard bench for phase_stall_ctrl: the driver queues hand-computed outputs per cycle,
// a negedge monitor pops and compares {memReq, notUpdate, phaseError, timeoutError}.
module tb_phase_stall_ctrl;

    localparam logic [4:0] P_ACC  = 5'b00100;
    localparam logic [4:0] P_NEXT = 5'b01000;
    localparam logic [4:0] P_0    = 5'b00001;
    localparam logic [4:0] P_1    = 5'b00010;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] phase;
    logic       needMem;
    logic       memAck;
    logic       memReq;
    logic       notUpdate;
    logic       phaseError;
    logic       timeoutError;

    typedef struct {
        logic [3:0] v;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    phase_stall_ctrl #(
        .ACCESS_PHASE  (2),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .phase       (phase),
        .needMem     (needMem),
        .memAck      (memAck),
        .memReq      (memReq),
        .notUpdate   (notUpdate),
        .phaseError  (phaseError),
        .timeoutError(timeoutError)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic rst, input logic [4:0] ph, input logic nm,
                        input logic ack, input logic [3:0] e, input string name);
        @(posedge clock);
        #1;
        reset   = rst;
        phase   = ph;
        needMem = nm;
        memAck  = ack;
        sb_q.push_back('{v: e, name: name});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({memReq, notUpdate, phaseError, timeoutError} !== e.v) begin
                    failures++;
                    $display("FAIL %s: req/nu/pe/te got=%b want=%b", e.name,
                             {memReq, notUpdate, phaseError, timeoutError}, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : driver
        reset   = 1'b0;
        phase   = P_ACC;
        needMem = 1'b1;
        memAck  = 1'b0;

        step(1'b0, P_ACC, 1'b1, 1'b0, 4'b0000, "rst_hold0");
        step(1'b0, P_ACC, 1'b1, 1'b0, 4'b0000, "rst_hold1");

        // Ack seen three cycles after memReq rises: four stall cycles.
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b0100, "bas_idle_stall");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "bas_req1");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "bas_req2");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "bas_req3");
        step(1'b1, P_ACC,  1'b1, 1'b1, 4'b1000, "bas_ack");
        step(1'b1, P_NEXT, 1'b1, 1'b0, 4'b0000, "bas_done");
        step(1'b1, P_NEXT, 1'b1, 1'b0, 4'b0000, "bas_idle");

        step(1'b1, P_ACC,  1'b1, 1'b1, 4'b0100, "imm_idle_ackign");
        step(1'b1, P_ACC,  1'b1, 1'b1, 4'b1000, "imm_req_ack");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b0000, "hold_done0");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b0000, "hold_done1");
        step(1'b1, P_ACC,  1'b1, 1'b1, 4'b0000, "hold_done_ack");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b0000, "hold_done2");
        step(1'b1, P_NEXT, 1'b1, 1'b0, 4'b0000, "hold_leave");
        step(1'b1, P_0,    1'b1, 1'b0, 4'b0000, "hold_idle");

        step(1'b1, P_ACC, 1'b1, 1'b0, 4'b0100, "nm_idle");
        step(1'b1, P_ACC, 1'b0, 1'b0, 4'b1100, "nm_req_drop");
        step(1'b1, P_ACC, 1'b0, 1'b1, 4'b1000, "nm_req_ack");
        step(1'b1, P_1,   1'b0, 1'b0, 4'b0000, "nm_done");
        step(1'b1, P_1,   1'b0, 1'b0, 4'b0000, "nm_idle");

        step(1'b1, P_ACC, 1'b1, 1'b0, 4'b0100, "mr_idle");
        step(1'b1, P_ACC, 1'b1, 1'b0, 4'b1100, "mr_req");
        step(1'b0, P_ACC, 1'b1, 1'b0, 4'b1000, "mr_rst");
        step(1'b1, P_0,   1'b0, 1'b0, 4'b0000, "mr_after");

        step(1'b1, 5'b00110, 1'b1, 1'b0, 4'b0000, "ill_first");
        step(1'b1, P_0,      1'b1, 1'b0, 4'b0010, "ill_set");
        step(1'b1, P_0,      1'b1, 1'b0, 4'b0010, "ill_sticky");
        step(1'b0, P_0,      1'b0, 1'b0, 4'b0010, "ill_rst_edge");
        step(1'b1, 5'b00000, 1'b0, 1'b0, 4'b0000, "ill_zero");
        step(1'b0, P_0,      1'b0, 1'b0, 4'b0010, "ill_zero_set");
        step(1'b1, 5'b10100, 1'b1, 1'b0, 4'b0000, "ill_bit4");
        step(1'b1, P_0,      1'b0, 1'b0, 4'b0010, "ill_bit4_set");
        step(1'b0, P_0,      1'b0, 1'b0, 4'b0010, "ill_clr");
        step(1'b0, 5'b00110, 1'b0, 1'b0, 4'b0000, "ill_in_rst");
        step(1'b1, P_0,      1'b0, 1'b0, 4'b0000, "ill_in_rst_ign");

        step(1'b1, P_ACC, 1'b1, 1'b0, 4'b0100, "to_idle");
`ifdef PHASE_STALL_TIMEOUT_EN
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "to_req1");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "to_req2");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1100, "to_req3");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b1000, "to_expire");
        step(1'b1, P_ACC,  1'b1, 1'b0, 4'b0001, "to_done_err");
        step(1'b1, P_NEXT, 1'b1, 1'b0, 4'b0001, "to_leave");
        step(1'b1, P_NEXT, 1'b1, 1'b0, 4'b0001, "to_idle_sticky");
        step(1'b0, P_NEXT, 1'b0, 1'b0, 4'b0001, "to_rst");
        step(1'b1, P_NEXT, 1'b0, 1'b0, 4'b0000, "to_cleared");
`else
        for (int i = 0; i < 50; i++) begin
            step(1'b1, P_ACC, 1'b1, 1'b0, 4'b1100, "nto_wait");
        end
        step(1'b1, P_ACC,  1'b1, 1'b1, 4'b1000, "nto_ack");
        step(1'b1, P_NEXT, 1'b0, 1'b0, 4'b0000, "nto_done");
        step(1'b1, P_NEXT, 1'b0, 1'b0, 4'b0000, "nto_idle");
`endif

        repeat (2) @(posedge clock);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
